// File: rtl/str_ofs_pkg.sv
// str_ofs_pkg
//  Shared definitions for the stream offset packer/unpacker pair:
//  - state_t   : control states of the re-alignment engine
//  - log2      : ceiling log2, used to size lane-offset fields
//  - lane_mask : n low lanes set, used for contiguous-keep checks
package str_ofs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest lane count supported by lane_mask (1024-bit bus of bytes).
  localparam int MAX_LANES = 128;

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask(input int n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/str_lane_shift.sv
// str_lane_shift
//  Combinational byte-lane barrel shifter for data and keep together.
//  Ports:
//   i_data / i_keep : input lanes (lane 0 = least significant)
//   i_amt           : shift distance in lanes
//   i_dir           : 0 = toward higher lanes (left), 1 = toward lower lanes (right)
//   o_data / o_keep : shifted lanes, vacated lanes are zero
module str_lane_shift
  import str_ofs_pkg::*;
#(
  parameter int LANES = 64,
  parameter int BW    = 8,
  parameter int AMT_W = 6
) (
  input  logic [LANES*BW-1:0] i_data,
  input  logic [LANES-1:0]    i_keep,
  input  logic [AMT_W-1:0]    i_amt,
  input  logic                i_dir,
  output logic [LANES*BW-1:0] o_data,
  output logic [LANES-1:0]    o_keep
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BW-1:0] lane_d;
      logic          lane_k;

      // Each output lane picks its source lane; out-of-range sources give zero.
      always_comb begin
        int src;
        src    = i_dir ? (gi + int'(i_amt)) : (gi - int'(i_amt));
        lane_d = '0;
        lane_k = 1'b0;
        if (src >= 0 && src < LANES) begin
          lane_d = i_data[src*BW +: BW];
          lane_k = i_keep[src];
        end
      end

      assign o_data[gi*BW +: BW] = lane_d;
      assign o_keep[gi]          = lane_k;
    end
  endgenerate

endmodule

// File: rtl/str_ofs_unpack.sv
// str_ofs_unpack
//  Re-aligns a dense AXI-stream packet so its first byte lands on lane
//  i_conv_m_ofs, for a write master targeting an unaligned address.
//  Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_conv_vld/o_conv_rdy     : command handshake, i_conv_m_ofs = first-byte lane
//   s_axis_*                  : dense input stream (lane 0 upward)
//   m_axis_*                  : aligned output stream, single output register
module str_ofs_unpack
  import str_ofs_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int BYTE_WIDTH = 8,
  parameter     SIM        = "FALSE",
  parameter     DEBUG      = "FALSE",
  parameter int BYTE_CNT   = DATA_WIDTH / BYTE_WIDTH,
  parameter int OFS_W      = log2(DATA_WIDTH / BYTE_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_conv_vld,
  output logic                  o_conv_rdy,
  input  logic [OFS_W-1:0]      i_conv_m_ofs,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [BYTE_CNT-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvld,
  output logic                  s_axis_trdy,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [BYTE_CNT-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvld,
  input  logic                  m_axis_trdy
);

  state_t                state_reg, state_next;
  logic [OFS_W-1:0]      ofs_reg, ofs_next;
  logic [DATA_WIDTH-1:0] hold_data_reg, hold_data_next;
  logic [BYTE_CNT-1:0]   hold_keep_reg, hold_keep_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic [BYTE_CNT-1:0]   out_keep_reg, out_keep_next;
  logic                  out_last_reg, out_last_next;
  logic                  out_vld_reg, out_vld_next;

  logic                  free;
  logic                  in_fire;
  logic                  out_fire;
  logic [OFS_W-1:0]      rsh_amt;
  logic [DATA_WIDTH-1:0] shl_data, shr_data;
  logic [BYTE_CNT-1:0]   shl_keep, shr_keep;
  logic [BYTE_CNT-1:0]   new_hold_keep;

  assign free        = !out_vld_reg || m_axis_trdy;
  assign s_axis_trdy = (state_reg == XFER) && free;
  assign in_fire     = s_axis_tvld && s_axis_trdy;
  assign out_fire    = out_vld_reg && m_axis_trdy;
  assign o_conv_rdy  = (state_reg == IDLE);

  // Lanes pushed past the top of the bus carry over to the next beat; the
  // carry distance is BYTE_CNT-ofs (wraps to 0 for ofs==0, where hold is unused).
  assign rsh_amt = OFS_W'(BYTE_CNT - int'(ofs_reg));

  str_lane_shift #(.LANES(BYTE_CNT), .BW(BYTE_WIDTH), .AMT_W(OFS_W)) u_shl (
    .i_data (s_axis_tdata),
    .i_keep (s_axis_tkeep),
    .i_amt  (ofs_reg),
    .i_dir  (1'b0),
    .o_data (shl_data),
    .o_keep (shl_keep)
  );

  str_lane_shift #(.LANES(BYTE_CNT), .BW(BYTE_WIDTH), .AMT_W(OFS_W)) u_shr (
    .i_data (s_axis_tdata),
    .i_keep (s_axis_tkeep),
    .i_amt  (rsh_amt),
    .i_dir  (1'b1),
    .o_data (shr_data),
    .o_keep (shr_keep)
  );

  assign new_hold_keep = (ofs_reg == '0) ? '0 : shr_keep;

  always_comb begin
    state_next     = state_reg;
    ofs_next       = ofs_reg;
    hold_data_next = hold_data_reg;
    hold_keep_next = hold_keep_reg;
    out_data_next  = out_data_reg;
    out_keep_next  = out_keep_reg;
    out_last_next  = out_last_reg;
    out_vld_next   = out_vld_reg;

    // A consumed beat empties the register unless a new one is loaded below.
    if (out_fire) out_vld_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_conv_vld) begin
          ofs_next       = i_conv_m_ofs;
          hold_data_next = '0;
          hold_keep_next = '0;
          state_next     = XFER;
        end
      end
      XFER: begin
        if (in_fire) begin
          out_data_next  = shl_data | hold_data_reg;
          out_keep_next  = shl_keep | hold_keep_reg;
          out_vld_next   = 1'b1;
          hold_data_next = (ofs_reg == '0) ? '0 : shr_data;
          hold_keep_next = new_hold_keep;
          out_last_next  = s_axis_tlast && (new_hold_keep == '0);
          if (s_axis_tlast) state_next = (new_hold_keep == '0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (free) begin
          out_data_next  = hold_data_reg;
          out_keep_next  = hold_keep_reg;
          out_last_next  = 1'b1;
          out_vld_next   = 1'b1;
          hold_data_next = '0;
          hold_keep_next = '0;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (out_fire && out_last_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      ofs_reg       <= '0;
      hold_data_reg <= '0;
      hold_keep_reg <= '0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_vld_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ofs_reg       <= ofs_next;
      hold_data_reg <= hold_data_next;
      hold_keep_reg <= hold_keep_next;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= out_last_next;
      out_vld_reg   <= out_vld_next;
    end
  end

  assign m_axis_tdata = out_data_reg;
  assign m_axis_tkeep = out_keep_reg;
  assign m_axis_tlast = out_last_reg;
  assign m_axis_tvld  = out_vld_reg;

  generate
    if (DEBUG == "TRUE") begin : g_dbg
      (* mark_debug = "true" *) state_t              dbg_state;
      (* mark_debug = "true" *) logic [BYTE_CNT-1:0] dbg_hold_keep;
      assign dbg_state     = state_reg;
      assign dbg_hold_keep = hold_keep_reg;
    end
  endgenerate

  generate
    if (SIM == "TRUE") begin : g_sim
      a_nonlast_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (s_axis_tvld && s_axis_trdy && !s_axis_tlast) |-> (&s_axis_tkeep));
      a_last_contig: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (s_axis_tvld && s_axis_trdy && s_axis_tlast) |->
          ((s_axis_tkeep != '0) &&
           (s_axis_tkeep == BYTE_CNT'(lane_mask($countones(s_axis_tkeep))))));
    end
  endgenerate

endmodule

// File: tb/tb_str_ofs_unpack.sv
// tb_str_ofs_unpack
//  Scoreboard bench at DATA_WIDTH=64: expected beats are computed from a
//  byte-position model when each command is issued; a monitor pops and
//  compares on every output handshake and checks stability under stall.
module tb_str_ofs_unpack;

  localparam int DW = 64;
  localparam int BC = 8;
  localparam int OW = 3;

  typedef struct {
    logic [DW-1:0] d;
    logic [BC-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          conv_vld;
  logic          conv_rdy;
  logic [OW-1:0] conv_ofs;
  logic [DW-1:0] s_tdata;
  logic [BC-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_tvld;
  logic          s_trdy;
  logic [DW-1:0] m_tdata;
  logic [BC-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvld;
  logic          m_trdy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int last_tlast_cyc = -100;
  int accept_cyc = 0;
  int prev_tlast = 0;
  bit rand_trdy = 1'b0;

  beat_t        exp_q[$];
  byte unsigned pkt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  str_ofs_unpack #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .SIM("TRUE")) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_conv_vld   (conv_vld),
    .o_conv_rdy   (conv_rdy),
    .i_conv_m_ofs (conv_ofs),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .s_axis_tvld  (s_tvld),
    .s_axis_trdy  (s_trdy),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .m_axis_tvld  (m_tvld),
    .m_axis_trdy  (m_trdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_pkt(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: byte p of the packet sits at absolute lane position ofs+p.
  task automatic push_expected(input int ofs);
    int total;
    int nb;
    total = ofs + pkt.size();
    nb    = (total + BC - 1) / BC;
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.d = '0;
      b.k = '0;
      b.l = (i == nb - 1);
      for (int ln = 0; ln < BC; ln++) begin
        int p;
        p = i * BC + ln;
        if (p >= ofs && p < total) begin
          b.d[ln*8 +: 8] = pkt[p - ofs];
          b.k[ln]        = 1'b1;
        end
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_cmd(input int ofs, input bit hold);
    bit ok;
    conv_vld = 1'b1;
    conv_ofs = OW'(ofs);
    push_expected(ofs);
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (conv_rdy) begin
        accept_cyc = cyc + 1;
        prev_tlast = last_tlast_cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) conv_vld = 1'b0;
  endtask

  task automatic drive_beats(input int maxb, input bit lat_chk);
    int nin;
    bit ok;
    nin = (pkt.size() + BC - 1) / BC;
    for (int i = 0; i < nin && i < maxb; i++) begin
      int cnt;
      cnt = (i == nin - 1) ? (pkt.size() - i * BC) : BC;
      s_tdata = '0;
      s_tkeep = '0;
      for (int j = 0; j < cnt; j++) begin
        s_tdata[j*8 +: 8] = pkt[i*BC + j];
        s_tkeep[j]        = 1'b1;
      end
      s_tlast = (i == nin - 1);
      s_tvld  = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
        @(negedge clk);
        if (s_trdy) begin ok = 1'b1; break; end
      end
      if (!ok) chk("in_timeout", 0, 1);
      @(posedge clk); #1;
      if (lat_chk && i == 0) chk("latency1_vld", 64'(m_tvld), 1);
    end
    s_tvld  = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_q_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic send_pkt(input int ofs, input int n, input int exp_beats, input string name);
    int p0;
    p0 = pops;
    fill_pkt(n);
    issue_cmd(ofs, 1'b0);
    drive_beats(1000, 1'b0);
    drain();
    if (exp_beats > 0) chk({name, "_beats"}, 64'(pops - p0), 64'(exp_beats));
    $display("pkt %s ofs=%0d bytes=%0d beats=%0d", name, ofs, n, pops - p0);
  endtask

  // Output ready: always 1, or a random toggle while rand_trdy is set.
  initial begin
    m_trdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_trdy = rand_trdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: transfers happen at the posedge following a negedge where vld&rdy.
  initial begin
    bit    stall;
    beat_t st;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else if (m_tvld) begin
        if (stall) begin
          chk("stall_data", m_tdata, st.d);
          chk("stall_keep", 64'(m_tkeep), 64'(st.k));
          chk("stall_last", 64'(m_tlast), 64'(st.l));
        end
        if (m_trdy) begin
          stall = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            beat_t e;
            logic [DW-1:0] msk;
            e = exp_q.pop_front();
            msk = '0;
            for (int ln = 0; ln < BC; ln++) if (e.k[ln]) msk[ln*8 +: 8] = 8'hFF;
            chk("out_keep", 64'(m_tkeep), 64'(e.k));
            chk("out_last", 64'(m_tlast), 64'(e.l));
            chk("out_data", m_tdata & msk, e.d);
            pops++;
            if (m_tlast) last_tlast_cyc = cyc + 1;
            $display("beat d=%016h k=%02h l=%0b", m_tdata, m_tkeep, m_tlast);
          end
        end else begin
          stall = 1'b1;
          st.d  = m_tdata;
          st.k  = m_tkeep;
          st.l  = m_tlast;
        end
      end else if (stall) begin
        chk("vld_dropped", 0, 1);
        stall = 1'b0;
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    conv_vld = 1'b0;
    conv_ofs = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tvld   = 1'b0;
    #12;
    chk("rst_conv_rdy", 64'(conv_rdy), 1);
    chk("rst_s_trdy", 64'(s_trdy), 0);
    chk("rst_m_tvld", 64'(m_tvld), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", 64'(m_tkeep), 0);
    chk("rst_m_tlast", 64'(m_tlast), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_trdy", 64'(s_trdy), 0);

    // 1: ofs 0, 12 bytes, latency check on first beat
    begin
      int p0;
      p0 = pops;
      fill_pkt(12);
      issue_cmd(0, 1'b0);
      drive_beats(1000, 1'b1);
      drain();
      chk("t1_beats", 64'(pops - p0), 2);
    end
    // 2, 3: fixed offsets
    send_pkt(3, 16, 3, "t2");
    send_pkt(5, 3, 1, "t3");
    // 4: random backpressure
    rand_trdy = 1'b1;
    send_pkt(2, 24, 4, "t4");
    rand_trdy = 1'b0;
    @(posedge clk); #1;

    // 5: reset after the first output beat of a 3-beat packet
    fill_pkt(16);
    issue_cmd(3, 1'b0);
    drive_beats(2, 1'b0);
    chk("t5_pre_rst_vld", 64'(m_tvld), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 64'(m_tvld), 0);
    chk("t5_rst_data", m_tdata, 0);
    chk("t5_rst_keep", 64'(m_tkeep), 0);
    chk("t5_rst_last", 64'(m_tlast), 0);
    chk("t5_rst_s_trdy", 64'(s_trdy), 0);
    chk("t5_rst_conv_rdy", 64'(conv_rdy), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(1, 11, 2, "t5_after");

    // 6: back-to-back commands with conv_vld held high
    fill_pkt(10);
    issue_cmd(4, 1'b1);
    drive_beats(1000, 1'b0);
    fill_pkt(9);
    issue_cmd(6, 1'b0);
    chk("t6_accept_gap", 64'(accept_cyc - prev_tlast), 1);
    drive_beats(1000, 1'b0);
    drain();

    // random packets under random backpressure
    rand_trdy = 1'b1;
    for (int r = 0; r < 12; r++) begin
      int ofs;
      int n;
      ofs = $urandom_range(0, BC - 1);
      n   = $urandom_range(1, 30);
      send_pkt(ofs, n, (ofs + n + BC - 1) / BC, "rnd");
    end
    rand_trdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
